// File: rtl/multi_cycle_control.sv
// Purpose : multi-cycle FSM controller sequencing IF/ID/EXE/MEM/WB for the CPU datapath.
// Latency : 2 cycles (NOP), 3 (beq), 4 (ALU ops, sw), 5 (lw); HALT holds until reset.
// Backpressure: none -- the controller free-runs, and only reset leaves HALT.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   opcode              instruction[31:26], sampled on the edge that leaves IF
//   zero                ALU zero flag, used only in EXE of beq
//   PCWre ... PCSrc     datapath enables and selects, combinational from state/op_q
//   state, halted       debug view of the FSM
//   retired             count of retired instructions, wraps at all-ones
module multi_cycle_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   output logic             PCWre,
   output logic             IRWre,
   output logic             RegWre,
   output logic             RegOut,
   output logic             Extsel,
   output logic             ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic             ALUM2Reg,
   output logic             DataMemRW,
   output logic             PCSrc,
   output logic [2:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b101
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_SUB  = 6'b000010;
   localparam logic [5:0] OP_ORI  = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_OR   = 6'b010010;
   localparam logic [5:0] OP_MOVE = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   // Static decode of the latched opcode; only applied to outputs in EXE/MEM/WB.
   logic       known;
   logic [2:0] alu_dec;
   logic       srcb_dec;
   logic       ext_dec;
   logic       rd_dst;

   always_comb begin
      known    = 1'b1;
      alu_dec  = 3'b000;
      srcb_dec = 1'b0;
      ext_dec  = 1'b1;
      rd_dst   = 1'b0;
      case (op_q)
         OP_ADD:  rd_dst = 1'b1;
         OP_ADDI: srcb_dec = 1'b1;
         OP_SUB:  begin alu_dec = 3'b001; rd_dst = 1'b1; end
         OP_ORI:  begin alu_dec = 3'b011; srcb_dec = 1'b1; ext_dec = 1'b0; end
         OP_AND:  begin alu_dec = 3'b100; ext_dec = 1'b0; rd_dst = 1'b1; end
         OP_OR:   begin alu_dec = 3'b011; ext_dec = 1'b0; rd_dst = 1'b1; end
         OP_MOVE: rd_dst = 1'b1;
         OP_SW:   srcb_dec = 1'b1;
         OP_LW:   srcb_dec = 1'b1;
         OP_BEQ:  alu_dec = 3'b001;
         OP_HALT: known = 1'b1;
         default: known = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      RegOut    = 1'b0;
      Extsel    = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      ALUM2Reg  = 1'b0;
      DataMemRW = 1'b0;
      PCSrc     = 1'b0;
      halted    = 1'b0;

      case (state_q)
         S_IF: begin
            IRWre   = 1'b1;
            op_d    = opcode;
            state_d = S_ID;
         end
         S_ID: begin
            if (op_q == OP_HALT) begin
               state_d = S_HALT;
            end else if (!known) begin
               // Unknown opcode retires as a 2-cycle NOP.
               PCWre   = 1'b1;
               state_d = S_IF;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            ALUOp   = alu_dec;
            ALUSrcB = srcb_dec;
            Extsel  = ext_dec;
            if (op_q == OP_BEQ) begin
               PCWre   = 1'b1;
               PCSrc   = zero;
               state_d = S_IF;
            end else if (op_q == OP_LW || op_q == OP_SW) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ALUOp   = alu_dec;
            ALUSrcB = srcb_dec;
            Extsel  = ext_dec;
            if (op_q == OP_SW) begin
               DataMemRW = 1'b1;
               PCWre     = 1'b1;
               state_d   = S_IF;
            end else begin
               state_d   = S_WB;
            end
         end
         S_WB: begin
            ALUOp    = alu_dec;
            ALUSrcB  = srcb_dec;
            Extsel   = ext_dec;
            RegWre   = 1'b1;
            RegOut   = rd_dst;
            ALUM2Reg = (op_q == OP_LW);
            PCWre    = 1'b1;
            state_d  = S_IF;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            // Unused encodings recover to fetch.
            state_d = S_IF;
         end
      endcase
   end

   // Exactly one PCWre pulse marks the end of each retired instruction.
   always_comb begin
      retired_d = retired_q;
      if (PCWre) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IF;
         op_q      <= 6'b000000;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         retired_q <= retired_d;
      end
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: each instruction is expanded from its class
// into the phase walk it should take, and every cycle's outputs are compared
// with what the instruction rules say that phase must show.
module tb_multi_cycle_control;

   // Narrow counter so the wrap scenario needs only a few hundred cycles.
   localparam int CNT_W = 8;

   localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
   localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_HALT = 5, K_NOP = 6;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [5:0]       opcode = 6'b0;
   logic             zero = 1'b0;
   logic             PCWre, IRWre, RegWre, RegOut, Extsel, ALUSrcB;
   logic [2:0]       ALUOp;
   logic             ALUM2Reg, DataMemRW, PCSrc;
   logic [2:0]       state;
   logic             halted;
   logic [CNT_W-1:0] retired;

   multi_cycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegOut(RegOut),
      .Extsel(Extsel), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ALUM2Reg(ALUM2Reg),
      .DataMemRW(DataMemRW), .PCSrc(PCSrc), .state(state), .halted(halted),
      .retired(retired)
   );

   always #5 clk = ~clk;

   logic [15:0] obs;
   assign obs = {PCWre, IRWre, RegWre, RegOut, Extsel, ALUSrcB, ALUOp,
                 ALUM2Reg, DataMemRW, PCSrc, halted, state};

   int checks = 0;
   int passes = 0;
   int model_ret = 0;

   logic [5:0] known_ops [10] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                  6'b010010, 6'b100000, 6'b100110, 6'b100111, 6'b110000};

   // Instruction table: class plus ALU function, B source and extension mode.
   function automatic void op_info(input logic [5:0] op, output int kind,
                                   output logic [2:0] aop, output logic sb, output logic ex);
      kind = K_NOP; aop = 3'b000; sb = 1'b0; ex = 1'b0;
      case (op)
         6'b000000: begin kind = K_R;    aop = 3'b000; sb = 1'b0; ex = 1'b1; end
         6'b000001: begin kind = K_I;    aop = 3'b000; sb = 1'b1; ex = 1'b1; end
         6'b000010: begin kind = K_R;    aop = 3'b001; sb = 1'b0; ex = 1'b1; end
         6'b010000: begin kind = K_I;    aop = 3'b011; sb = 1'b1; ex = 1'b0; end
         6'b010001: begin kind = K_R;    aop = 3'b100; sb = 1'b0; ex = 1'b0; end
         6'b010010: begin kind = K_R;    aop = 3'b011; sb = 1'b0; ex = 1'b0; end
         6'b100000: begin kind = K_R;    aop = 3'b000; sb = 1'b0; ex = 1'b1; end
         6'b100110: begin kind = K_SW;   aop = 3'b000; sb = 1'b1; ex = 1'b1; end
         6'b100111: begin kind = K_LW;   aop = 3'b000; sb = 1'b1; ex = 1'b1; end
         6'b110000: begin kind = K_BEQ;  aop = 3'b001; sb = 1'b0; ex = 1'b1; end
         6'b111111: begin kind = K_HALT; end
         default:   begin kind = K_NOP; end
      endcase
   endfunction

   function automatic logic [15:0] expect_vec(input int phase, input bit last,
                                              input logic [5:0] op, input logic z);
      int kind; logic [2:0] aop; logic sb, ex;
      logic [2:0] ao; logic es, bs;
      op_info(op, kind, aop, sb, ex);
      ao = 3'b000; es = 1'b0; bs = 1'b0;
      if (phase == P_EXE || phase == P_MEM || phase == P_WB) begin
         ao = aop; es = ex; bs = sb;
      end
      return {last,                                    // PCWre
              1'(phase == P_IF),                       // IRWre
              1'(phase == P_WB),                       // RegWre
              1'(phase == P_WB && kind == K_R),        // RegOut
              es, bs, ao,
              1'(phase == P_WB && kind == K_LW),       // ALUM2Reg
              1'(phase == P_MEM && kind == K_SW),      // DataMemRW
              1'(phase == P_EXE && kind == K_BEQ && z == 1'b1), // PCSrc
              1'(phase == P_HALT),                     // halted
              3'(phase)};
   endfunction

   // One clock of the instruction walk: drive, check outputs and counter, advance.
   task automatic step(input int phase, input bit last, input logic [5:0] op_l,
                       input logic [5:0] op_drive, input logic z_drive, input string tag);
      logic [15:0] exp;
      opcode = op_drive;
      zero   = z_drive;
      #1;
      exp = expect_vec(phase, last, op_l, z_drive);
      checks++;
      if (obs !== exp)
         $display("FAIL %s phase%0d outputs: got %h expected %h", tag, phase, obs, exp);
      else passes++;
      checks++;
      if (retired !== model_ret[CNT_W-1:0])
         $display("FAIL %s phase%0d retired: got %0d expected %0d", tag, phase, retired,
                  model_ret[CNT_W-1:0]);
      else passes++;
      @(posedge clk); #1;
      if (last) model_ret = (model_ret + 1) % (1 << CNT_W);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic z_exe, input string tag);
      int kind; logic [2:0] aop; logic sb, ex;
      int phases[$];
      op_info(op, kind, aop, sb, ex);
      case (kind)
         K_R, K_I: phases = '{P_IF, P_ID, P_EXE, P_WB};
         K_LW:     phases = '{P_IF, P_ID, P_EXE, P_MEM, P_WB};
         K_SW:     phases = '{P_IF, P_ID, P_EXE, P_MEM};
         K_BEQ:    phases = '{P_IF, P_ID, P_EXE};
         default:  phases = '{P_IF, P_ID};
      endcase
      for (int i = 0; i < phases.size(); i++) begin
         step(phases[i], (i == phases.size() - 1) && kind != K_HALT, op,
              (phases[i] == P_IF) ? op : 6'($urandom),
              (phases[i] == P_EXE) ? z_exe : 1'($urandom), tag);
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #2;
      checks++;
      if (obs !== expect_vec(P_IF, 1'b0, 6'b0, 1'b0))
         $display("FAIL %s reset outputs: got %h expected %h", tag, obs,
                  expect_vec(P_IF, 1'b0, 6'b0, 1'b0));
      else passes++;
      checks++;
      if (retired !== '0) $display("FAIL %s reset retired: got %0d expected 0", tag, retired);
      else passes++;
      model_ret = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_add();
      do_reset("add_rst");
      for (int i = 0; i < 3; i++) run_instr(6'b000000, 1'($urandom), "add");
      checks++;
      if (retired !== CNT_W'(3)) $display("FAIL add_count retired: got %0d expected 3", retired);
      else passes++;
   endtask

   task automatic test_lw_sw();
      run_instr(6'b100111, 1'b1, "lw");
      run_instr(6'b100110, 1'b1, "sw");
   endtask

   task automatic test_beq();
      run_instr(6'b110000, 1'b1, "beq_taken");
      run_instr(6'b110000, 1'b0, "beq_not_taken");
   endtask

   task automatic test_ori_nop();
      run_instr(6'b010000, 1'b1, "ori");
      run_instr(6'b000111, 1'b1, "nop");
   endtask

   task automatic test_random();
      logic [5:0] op;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(3) == 0) begin
            op = 6'($urandom);
            if (op == 6'b111111) op = 6'b111110;
         end else begin
            op = known_ops[$urandom_range(9)];
         end
         run_instr(op, 1'($urandom), "random");
      end
   endtask

   task automatic test_halt();
      run_instr(6'b111111, 1'b0, "halt");
      for (int i = 0; i < 20; i++)
         step(P_HALT, 1'b0, 6'b111111, 6'($urandom), 1'($urandom), "halt_hold");
      do_reset("halt_rst");
      run_instr(6'b000001, 1'b0, "addi_after_halt");
   endtask

   task automatic test_wrap();
      do_reset("wrap_rst");
      for (int i = 0; i < (1 << CNT_W) - 2; i++) run_instr(6'b000111, 1'b0, "wrap_nop");
      checks++;
      if (retired !== {{(CNT_W-1){1'b1}}, 1'b0})
         $display("FAIL wrap_preload retired: got %0d expected %0d", retired, (1 << CNT_W) - 2);
      else passes++;
      run_instr(6'b000000, 1'b0, "wrap_add");
      run_instr(6'b100111, 1'b0, "wrap_lw");
      checks++;
      if (retired !== '0) $display("FAIL wrap_zero retired: got %0d expected 0", retired);
      else passes++;
   endtask

   task automatic test_reset_mid_sw();
      run_instr(6'b000000, 1'b0, "pre_sw_add");
      step(P_IF,  1'b0, 6'b100110, 6'b100110, 1'b0, "rst_sw");
      step(P_ID,  1'b0, 6'b100110, 6'($urandom), 1'b0, "rst_sw");
      step(P_EXE, 1'b0, 6'b100110, 6'($urandom), 1'b0, "rst_sw");
      #1;
      checks++;
      if (DataMemRW !== 1'b1) $display("FAIL rst_sw_mem DataMemRW: got %b expected 1", DataMemRW);
      else passes++;
      reset = 1'b1;
      #1;
      checks++;
      if (DataMemRW !== 1'b0 || PCWre !== 1'b0 || state !== 3'b000 || retired !== '0)
         $display("FAIL rst_sw_async dm/pcw/state/ret: got %b/%b/%0d/%0d expected 0/0/0/0",
                  DataMemRW, PCWre, state, retired);
      else passes++;
      model_ret = 0;
      @(negedge clk);
      reset = 1'b0;
      run_instr(6'b100110, 1'b0, "sw_after_rst");
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_sw();
      test_beq();
      test_ori_nop();
      test_random();
      test_halt();
      test_wrap();
      test_reset_mid_sw();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- FSM controller that sequences the existing CPU datapath (PC, instruction memory, register file, ALU, data memory) over several cycles per instruction, replacing single-cycle decode.
- Latches the opcode at end of fetch and walks IF/ID/EXE/MEM/WB.
- Asserts each write enable only in the cycle that commits it.
- Keeps a retired-instruction counter for debug and performance.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears state, latched opcode and counter
- opcode  in  6  instruction[31:26] from instruction memory, valid during IF
- zero  in  1  ALU zero flag, valid during EXE
- PCWre  out  1  PC load enable, high for exactly one cycle per instruction
- IRWre  out  1  instruction register load enable
- RegWre  out  1  register file write enable
- RegOut  out  1  write-register select: 0 = rt, 1 = rd
- Extsel  out  1  immediate extension: 1 = sign, 0 = zero
- ALUSrcB  out  1  ALU B select: 0 = register, 1 = extended immediate
- ALUOp  out  3  ALU function: 000 add, 001 sub, 011 or, 100 and
- ALUM2Reg  out  1  writeback select: 0 = ALU result, 1 = data memory
- DataMemRW  out  1  data memory write enable: 1 = write
- PCSrc  out  1  next-PC select: 0 = PC+4, 1 = branch target
- state  out  3  current FSM state, for debug
- halted  out  1  high while in HALT
- retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
- Reset (asynchronous):
  - state=IF, op_q=6'b000000, retired=0.
  - Every output derived from state IF: IRWre=1, all other enables 0.
- Outputs are combinational from (state, op_q); PCSrc is also a function of zero.
- IF:
  - IRWre=1.
  - op_q<=opcode on the exiting edge.
  - Next state is ID.
- ID: decode only, no enables asserted.
  - halt (111111) goes to HALT.
  - Unknown opcode: PCWre=1, PCSrc=0, go to IF (2-cycle NOP).
  - All other opcodes go to EXE.
- EXE: ALUOp, ALUSrcB and Extsel are driven for op_q and held through MEM and WB.
  - add 000000: ALUOp=000, ALUSrcB=0, Extsel=1.
  - addi 000001: ALUOp=000, ALUSrcB=1, Extsel=1.
  - sub 000010: ALUOp=001, ALUSrcB=0, Extsel=1.
  - ori 010000: ALUOp=011, ALUSrcB=1, Extsel=0.
  - and 010001: ALUOp=100, ALUSrcB=0, Extsel=0.
  - or 010010: ALUOp=011, ALUSrcB=0, Extsel=0.
  - move 100000: ALUOp=000, ALUSrcB=0, Extsel=1.
  - sw 100110 and lw 100111: ALUOp=000, ALUSrcB=1, Extsel=1.
  - beq 110000: ALUOp=001, ALUSrcB=0, Extsel=1.
  - beq: PCWre=1, PCSrc=zero, then go to IF (3 cycles total).
  - lw and sw go to MEM; all ALU ops go to WB.
- MEM:
  - sw: DataMemRW=1, PCWre=1, PCSrc=0, then IF (4 cycles).
  - lw: DataMemRW=0, then WB.
- WB:
  - RegWre=1, PCWre=1, PCSrc=0, then IF.
  - RegOut=1 for add/sub/and/or/move, 0 for addi/ori/lw.
  - ALUM2Reg=1 only for lw.
  - Cycle counts: ALU ops 4, lw 5.
- Enable rules:
  - PCWre is never high outside the final cycle of an instruction.
  - RegWre is high only in WB; DataMemRW only in MEM for sw.
  - RegWre and DataMemRW are never high together.
- retired increments by 1 on every edge where PCWre=1, and wraps from all-ones to 0.
  - NOP counts as retired.
  - halt does not count.
- HALT:
  - All enables are 0 and halted=1.
  - The state is held until reset; the opcode and zero inputs are ignored.
- Reset asserted mid-instruction: state returns to IF immediately (asynchronous) and in-flight enables drop the same instant. There is no partial commit after reset.
- zero is ignored in every state except EXE with op_q=beq.

Test Plan:
- Reset, then hold opcode=000000 (add) → state sequence IF,ID,EXE,WB,IF. RegWre=1 and RegOut=1 only in WB. PCWre pulses once per 4 cycles. retired=3 after 12 cycles.
- lw (100111) then sw (100110) → lw takes 5 cycles with ALUM2Reg=1, RegWre=1 in WB and RegOut=0. sw takes 4 cycles with DataMemRW=1 only in MEM and RegWre=0 throughout.
- beq (110000) with zero=1 in EXE → PCSrc=1 and PCWre=1 in cycle 3. With zero=0 → PCSrc=0. zero toggled during IF/ID has no effect.
- ori (010000) → Extsel=0, ALUOp=011, ALUSrcB=1 from EXE through WB. Unknown opcode 000111 → 2-cycle NOP with retired incremented.
- halt (111111) → HALT after ID, halted=1, PCWre stays 0 for 20 cycles despite opcode changes. Asserting reset returns state to IF with retired=0.
- Preload retired=16'hFFFE via reset-free run, retire 2 instructions → counter reaches 0. Separately, pulse reset during MEM of sw → DataMemRW drops immediately and state=IF.
